// File: rtl/pbs_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pbs_ctrl
//  Purpose  : Turn-sequencing controller for the battle simulator. Latches
//             the player's move, strobes damage for the player and the AI in
//             alternation, watches both HP buses for the end of the game and
//             counts completed turns.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             move_sel/move_go- player move index / commit level (edge-detected)
//             p_hp, ai_hp     - HP feedback from the datapath
//             p_move, actr, target, app_dmg - datapath control (registered)
//             turn_cnt        - completed full turns, saturating
//             game_over/winner- end-of-game flag and winner (0 player, 1 AI)
//             state_o         - current state encoding for debug/LEDs
//  Options  : PBS_CTRL_TIMEOUT_EN - player forfeits the attack after TIMEOUT
//             idle cycles without a move_go edge.
//  Revision : 1.0 - initial release
// ============================================================================
module pbs_ctrl #(
   parameter int HP_W     = 4,
   parameter int TURN_W   = 8,
   parameter int AI_DELAY = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        move_sel,
   input  logic              move_go,
   input  logic [HP_W-1:0]   p_hp,
   input  logic [HP_W-1:0]   ai_hp,
   output logic [1:0]        p_move,
   output logic              actr,
   output logic              target,
   output logic              app_dmg,
   output logic [TURN_W-1:0] turn_cnt,
   output logic              game_over,
   output logic              winner,
   output logic [3:0]        state_o
);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_P_SEL     = 4'd1,
      ST_P_HIT     = 4'd2,
      ST_P_SETTLE  = 4'd3,
      ST_P_CHECK   = 4'd4,
      ST_AI_WAIT   = 4'd5,
      ST_AI_SEL    = 4'd6,
      ST_AI_HIT    = 4'd7,
      ST_AI_SETTLE = 4'd8,
      ST_AI_CHECK  = 4'd9,
      ST_DONE      = 4'd10
   } state_t;

   localparam int             DLY_W    = (AI_DELAY > 1) ? $clog2(AI_DELAY) : 1;
   localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(AI_DELAY - 1);
   localparam int             TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [1:0]        p_move_q, p_move_d;
   logic              actr_q, actr_d;
   logic              target_q, target_d;
   logic              app_dmg_q, app_dmg_d;
   logic [TURN_W-1:0] turn_q, turn_d;
   logic              game_over_q, game_over_d;
   logic              winner_q, winner_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic              go_q, go_d;
   logic              go_edge;

`ifdef PBS_CTRL_TIMEOUT_EN
   logic [TO_W-1:0]   to_q, to_d;
`else
   logic [TO_W-1:0]   unused_timeout;
   assign unused_timeout = TO_LAST;
`endif

   assign go_edge = move_go & ~go_q;

   always_comb begin
      state_d     = state_q;
      p_move_d    = p_move_q;
      actr_d      = actr_q;
      target_d    = target_q;
      turn_d      = turn_q;
      winner_d    = winner_q;
      dly_d       = dly_q;
      go_d        = move_go;

      case (state_q)
         ST_IDLE: begin
            if (go_edge) begin
               p_move_d = move_sel;
               state_d  = ST_P_SEL;
            end
`ifdef PBS_CTRL_TIMEOUT_EN
            // An edge in the expiry cycle takes priority over the forfeit.
            else if (to_q == TO_LAST) begin
               dly_d   = DLY_LOAD;
               state_d = ST_AI_WAIT;
            end
`endif
         end
         ST_P_SEL:    state_d = ST_P_HIT;
         ST_P_HIT:    state_d = ST_P_SETTLE;
         ST_P_SETTLE: state_d = ST_P_CHECK;
         ST_P_CHECK: begin
            if (ai_hp == '0) begin
               winner_d = 1'b0;
               state_d  = ST_DONE;
            end else begin
               dly_d   = DLY_LOAD;
               state_d = ST_AI_WAIT;
            end
         end
         ST_AI_WAIT: begin
            // Loaded with AI_DELAY-1 so the dwell is AI_DELAY cycles.
            if (dly_q == '0) state_d = ST_AI_SEL;
            else             dly_d   = dly_q - DLY_W'(1);
         end
         ST_AI_SEL:    state_d = ST_AI_HIT;
         ST_AI_HIT:    state_d = ST_AI_SETTLE;
         ST_AI_SETTLE: state_d = ST_AI_CHECK;
         ST_AI_CHECK: begin
            if (p_hp == '0) begin
               winner_d = 1'b1;
               state_d  = ST_DONE;
            end else begin
               if (turn_q != '1) turn_d = turn_q + TURN_W'(1);
               state_d = ST_IDLE;
            end
         end
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so that the registered
      // value lines up with the state it belongs to.
      if (state_d == ST_P_SEL) begin
         actr_d   = 1'b0;
         target_d = 1'b1;
      end else if (state_d == ST_AI_SEL) begin
         actr_d   = 1'b1;
         target_d = 1'b0;
      end
      app_dmg_d   = (state_d == ST_P_HIT) || (state_d == ST_AI_HIT);
      game_over_d = (state_d == ST_DONE);

`ifdef PBS_CTRL_TIMEOUT_EN
      to_d = ((state_q == ST_IDLE) && (state_d == ST_IDLE)) ? to_q + TO_W'(1) : '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         p_move_q    <= 2'd0;
         actr_q      <= 1'b0;
         target_q    <= 1'b1;
         app_dmg_q   <= 1'b0;
         turn_q      <= '0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
         dly_q       <= '0;
         go_q        <= 1'b0;
`ifdef PBS_CTRL_TIMEOUT_EN
         to_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         p_move_q    <= p_move_d;
         actr_q      <= actr_d;
         target_q    <= target_d;
         app_dmg_q   <= app_dmg_d;
         turn_q      <= turn_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
         dly_q       <= dly_d;
         go_q        <= go_d;
`ifdef PBS_CTRL_TIMEOUT_EN
         to_q        <= to_d;
`endif
      end
   end

   assign p_move    = p_move_q;
   assign actr      = actr_q;
   assign target    = target_q;
   assign app_dmg   = app_dmg_q;
   assign turn_cnt  = turn_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;
   assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pbs_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pbs_ctrl
//  Purpose  : Scoreboard bench for pbs_ctrl. Stimulus plays random turns and
//             pushes the expected datapath events (damage strobes, game end,
//             turn completion) with the cycle they must appear in; a monitor
//             pops and compares whenever the DUT shows one of those events.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pbs_ctrl;

   localparam int HP_W     = 4;
   localparam int TURN_W   = 8;
   localparam int AI_DELAY = 4;
   localparam int TIMEOUT  = 64;

   localparam int EV_HIT  = 0;
   localparam int EV_DONE = 1;
   localparam int EV_TURN = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        move_sel = 2'd0;
   logic              move_go = 1'b0;
   logic [HP_W-1:0]   p_hp = 4'd15;
   logic [HP_W-1:0]   ai_hp = 4'd15;
   logic [1:0]        p_move;
   logic              actr, target, app_dmg, game_over, winner;
   logic [TURN_W-1:0] turn_cnt;
   logic [3:0]        state_o;

   pbs_ctrl #(.HP_W(HP_W), .TURN_W(TURN_W), .AI_DELAY(AI_DELAY), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .move_sel(move_sel), .move_go(move_go),
      .p_hp(p_hp), .ai_hp(ai_hp), .p_move(p_move), .actr(actr),
      .target(target), .app_dmg(app_dmg), .turn_cnt(turn_cnt),
      .game_over(game_over), .winner(winner), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int cycle;
      int a;
      int t;
      int pm;
      int val;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  m_turn = 0;   // reference turn count

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int cycle, input int a, input int t,
                          input int pm, input int val);
      ev_t e;
      e.kind = kind; e.cycle = cycle; e.a = a; e.t = t; e.pm = pm; e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         check("ev_kind", kind, e.kind);
         check("ev_cycle", cyc, e.cycle);
         case (kind)
            EV_HIT: begin
               check("hit_actr", int'(actr), e.a);
               check("hit_target", int'(target), e.t);
               check("hit_p_move", int'(p_move), e.pm);
            end
            EV_DONE: check("done_winner", int'(winner), e.val);
            default: check("turn_cnt", int'(turn_cnt), e.val);
         endcase
      end
   endtask

   // Monitor: decoupled from stimulus, reacts to DUT-presented events.
   logic       prev_dmg = 1'b0;
   logic       prev_go  = 1'b0;
   logic [3:0] prev_st  = 4'd0;
   always @(negedge clk) begin
      if (app_dmg) begin
         check("dmg_gap", int'(prev_dmg), 0);
         pop_cmp(EV_HIT);
      end
      if (game_over && !prev_go) pop_cmp(EV_DONE);
      if (state_o == 4'd0 && prev_st == 4'd9) pop_cmp(EV_TURN);
      prev_dmg <= app_dmg;
      prev_go  <= game_over;
      prev_st  <= state_o;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Two cycles of reset, then check the reset state while rst is still high.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      move_go = 1'b0;
      tick(2);
      exp_q.delete();
      m_turn = 0;
      check("rst_state", int'(state_o), 0);
      check("rst_app_dmg", int'(app_dmg), 0);
      check("rst_actr", int'(actr), 0);
      check("rst_target", int'(target), 1);
      check("rst_turn_cnt", int'(turn_cnt), 0);
      check("rst_game_over", int'(game_over), 0);
      check("rst_winner", int'(winner), 0);
      check("rst_p_move", int'(p_move), 0);
      rst = 1'b0;
   endtask

   // One player commit from IDLE. Event times are relative to the cycle in
   // which move_go is raised (m): player hit m+2, player-win end m+5,
   // AI hit m+6+AI_DELAY, turn end / AI-win end m+9+AI_DELAY.
   task automatic play_turn(input logic [1:0] sel, input logic [HP_W-1:0] ahp,
                            input logic [HP_W-1:0] php, output bit ended);
      int m, dur, hold, pulse;
      m = cyc;
      ai_hp = ahp;
      p_hp = php;
      move_sel = sel;
      move_go = 1'b1;
      ended = 1'b0;
      push_ev(EV_HIT, m + 2, 0, 1, int'(sel), 0);
      if (ahp == 0) begin
         push_ev(EV_DONE, m + 5, 0, 0, 0, 0);
         ended = 1'b1;
         dur = 5;
      end else begin
         push_ev(EV_HIT, m + 6 + AI_DELAY, 1, 0, int'(sel), 0);
         dur = 9 + AI_DELAY;
         if (php == 0) begin
            push_ev(EV_DONE, m + dur, 0, 0, 0, 1);
            ended = 1'b1;
         end else begin
            m_turn = (m_turn < 255) ? m_turn + 1 : 255;
            push_ev(EV_TURN, m + dur, 0, 0, 0, m_turn);
         end
      end
      hold  = $urandom_range(1, dur + 4);
      pulse = (hold + 1 <= dur - 2 && $urandom_range(0, 1) == 1) ?
              $urandom_range(hold + 1, dur - 2) : -10;
      for (int i = 1; i <= dur + 1; i++) begin
         @(negedge clk);
         if (i == 2) move_sel = 2'($urandom);
         if (i == hold) move_go = 1'b0;
         if (i == pulse) move_go = 1'b1;
         if (i == pulse + 1) move_go = 1'b0;
      end
      // Held high into IDLE: must not retrigger.
      if (move_go) begin
         tick(hold - dur - 1);
         move_go = 1'b0;
      end
      tick(1 + $urandom_range(0, 4));
   endtask

   function automatic logic [HP_W-1:0] rand_hp(input int zero_odds);
      if ($urandom_range(0, zero_odds) == 0) return '0;
      return HP_W'($urandom_range(1, 15));
   endfunction

   // Reset arriving in AI_WAIT: IDLE next cycle and no AI damage afterwards.
   task automatic reset_in_wait();
      int m;
      m = cyc;
      ai_hp = 4'd9;
      p_hp = 4'd9;
      move_sel = 2'($urandom);
      move_go = 1'b1;
      push_ev(EV_HIT, m + 2, 0, 1, int'(move_sel), 0);
      tick(5 + $urandom_range(0, AI_DELAY - 1));
      move_go = 1'b0;
      rst = 1'b1;
      tick(1);
      check("midrst_state", int'(state_o), 0);
      check("midrst_app_dmg", int'(app_dmg), 0);
      rst = 1'b0;
      exp_q.delete();
      m_turn = 0;
      tick(15);
   endtask

   initial begin
      bit ended;
      do_reset();
      tick(1);

      // Random games: mixed HP, with ends, ignored commits and mid-turn resets.
      for (int g = 0; g < 40; g++) begin
         if ($urandom_range(0, 5) == 0) begin
            reset_in_wait();
         end else begin
            play_turn(2'($urandom), rand_hp(5), rand_hp(5), ended);
            if (ended) begin
               move_go = 1'b1;
               tick(2);
               move_go = 1'b0;
               tick(12);
               check("done_state", int'(state_o), 10);
               check("done_game_over", int'(game_over), 1);
               do_reset();
               tick(1);
            end
         end
      end

      // Long run without a winner to reach turn counter saturation.
      do_reset();
      tick(1);
      for (int t = 0; t < 258; t++) begin
         play_turn(2'($urandom), rand_hp(0) | 4'd1, rand_hp(0) | 4'd1, ended);
      end
      check("sat_turn_cnt", int'(turn_cnt), 255);

`ifdef PBS_CTRL_TIMEOUT_EN
      // Idle until expiry: AI attacks with no player damage, p_move kept.
      begin
         int r;
         ai_hp = 4'd5;
         p_hp = 4'd5;
         do_reset();
         r = cyc;
         push_ev(EV_HIT, r + TIMEOUT + AI_DELAY + 1, 1, 0, 0, 0);
         push_ev(EV_TURN, r + TIMEOUT + AI_DELAY + 4, 0, 0, 0, 1);
         tick(TIMEOUT + AI_DELAY + 6);
      end
`endif

      tick(20);
      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
